test_serail_fifo: RTL
=====================

// Module: test_serail_fifo
// PURPOSE
//  Parametrised simulation-only serial port for CPU bench runs, replacing the single-char test serial.
//  Sits on the serial bus of the MMU/bus mux. Buffers CPU writes in a TX FIFO drained to the sim console
//  at a programmable rate. Buffers bench-injected bytes in an RX FIFO for CPU reads.
//  Adds status/control registers, back-pressure, overrun detection and an interrupt line.
// PARAMETERS
//  DATA_W     32  bus data width (>=24)
//  ADDR_W     3   serial word-address width; decode uses addr[1:0], higher bits must be 0
//  TX_DEPTH   16  TX FIFO entries, power of 2, 2..128
//  RX_DEPTH   16  RX FIFO entries, power of 2, 2..128
//  TX_CYCLES  4   clocks per drained TX char (>=1)
// PORTS
//  clk             in   1       clock, all logic on posedge
//  rst             in   1       synchronous reset, active-low (rst==0 resets)
//  serail_data_o   out  DATA_W  read data, valid while serail_ready_o==1
//  serail_ready_o  out  1       access-complete, held until serail_ce_i drops
//  serail_addr_i   in   ADDR_W  word address
//  serail_data_i   in   DATA_W  write data
//  serail_we_i     in   1       1=write, 0=read
//  serail_ce_i     in   1       access request, held high until ready seen
//  inject_data_i   in   8       bench RX byte
//  inject_valid_i  in   1       push inject_data_i into RX this cycle
//  inject_ready_o  out  1       RX not full (informational; no stall)
//  irq_o           out  1       registered interrupt
// BEHAVIOUR
//  Reset: all FIFOs empty, drain counter 0, FSM IDLE.
//   Outputs: serail_data_o=0, serail_ready_o=0, irq_o=0, inject_ready_o=1. CTRL=0, OVR=0.
//  Map (addr): 0 DATA; 1 STATUS; 2 CTRL; others read 0, write ignored, still complete.
//   DATA wr: push data_i[7:0] to TX. DATA rd: pop RX, data_o={0,byte}; RX empty -> data_o=0, no pop.
//   STATUS rd: [0] TX not full, [1] RX not empty, [2] TX empty, [3] OVR sticky.
//    [15:8] RX count, [23:16] TX count, rest 0.
//   STATUS wr: data_i[3]=1 clears OVR; other bits ignored.
//   CTRL rd/wr: [0] RX_IE, [1] TX_IE; rest read 0.
//  Access FSM: IDLE, WAIT, DONE.
//   IDLE & ce=1: perform access at this edge, ready<=1 next cycle, ->DONE.
//    Exception: DATA write with TX full -> WAIT, ready stays 0.
//   WAIT: push on first edge a TX slot frees (same-edge drain pop counts), then ready<=1, ->DONE.
//    ce=0 in WAIT: abort, no push, ->IDLE.
//   DONE: ready held 1 while ce=1. ce=0 -> ready<=0, ->IDLE.
//   Exactly one side effect per ce assertion; ce held high never re-pushes or re-pops.
//   Min latency 1 cycle (edge after ce high). Next access needs ce low >=1 cycle.
//  TX drain: counter runs only while TX non-empty, else held 0.
//   On count==TX_CYCLES-1: pop head, $write("%c"), counter->0.
//   First char prints TX_CYCLES edges after TX becomes non-empty.
//  RX inject: inject_valid_i & !full pushes.
//   Full and no same-edge CPU pop: byte dropped, OVR<=1.
//   Full with same-edge pop: push accepted, no overrun.
//  Simultaneous push+pop on either FIFO: count unchanged, order preserved.
//  Pointers wrap modulo depth. Counts are width $clog2(DEPTH)+1.
//  irq_o <= (RX_IE & RX non-empty) | (TX_IE & TX empty); one-cycle lag from state change.
//  Reset mid-access or mid-drain: contents lost, undrained chars not printed.
//   ce high at reset release = new access on the first non-reset edge.
// TESTING
//  1 ce+we to DATA, data_i=0x41, TX_CYCLES=4 -> ready 1 cycle later; 'A' printed 4 edges after push.
//  2 TX_DEPTH+1 writes with no pauses -> last write in WAIT.
//    Ready comes exactly on the drain-pop edge; all chars print in order.
//  3 Inject RX_DEPTH+1 bytes -> STATUS[3]=1, RX count=RX_DEPTH.
//    Write STATUS 0x8 -> OVR=0. Reads return bytes FIFO-ordered; empty read=0.
//  4 Full RX, same cycle: inject 0x55 and CPU DATA-read pop -> no OVR, count stays RX_DEPTH.
//  5 CTRL=0x1, inject 0x10 -> irq_o=1 one cycle after push; DATA read -> irq_o=0.
//    CTRL=0x2 with TX empty -> irq_o=1.
//  6 rst=0 during WAIT with 3 chars queued -> next cycle: ready=0, counts 0, no further output.
//    ce held -> new access after release.

Source files
------------

// File: rtl/test_serail_fifo.sv
// Simulation serial port: CPU writes queue in a TX FIFO drained to the console at a fixed rate,
// bench-injected bytes queue in an RX FIFO for CPU reads, with status/control and an interrupt.
module test_serail_fifo #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 3,
   parameter int TX_DEPTH  = 16,
   parameter int RX_DEPTH  = 16,
   parameter int TX_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic [DATA_W-1:0] serail_data_o,
   output logic              serail_ready_o,
   input  logic [ADDR_W-1:0] serail_addr_i,
   input  logic [DATA_W-1:0] serail_data_i,
   input  logic              serail_we_i,
   input  logic              serail_ce_i,
   input  logic [7:0]        inject_data_i,
   input  logic              inject_valid_i,
   output logic              inject_ready_o,
   output logic              irq_o
);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int DR_W  = $clog2(TX_CYCLES + 1);
   localparam logic [TX_AW:0]  TX_FULL = (TX_AW+1)'(TX_DEPTH);
   localparam logic [RX_AW:0]  RX_FULL = (RX_AW+1)'(RX_DEPTH);
   localparam logic [DR_W-1:0] DR_LAST = DR_W'(TX_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] data_q;
   logic              ready_q, irq_q, ovr_q;
   logic [1:0]        ctrl_q;

   logic [7:0]       txMem_q [TX_DEPTH];
   logic [7:0]       rxMem_q [RX_DEPTH];
   logic [TX_AW-1:0] txWr_q, txRd_q;
   logic [RX_AW-1:0] rxWr_q, rxRd_q;
   logic [TX_AW:0]   txCount_q, txCount_d;
   logic [RX_AW:0]   rxCount_q, rxCount_d;
   logic [DR_W-1:0]  drain_q, drain_d;

   logic              addrOk, isData, isStatus, isCtrl, access;
   logic              txFull, txEmpty, rxFull, rxEmpty;
   logic              txPush, txPop, rxPush, rxPop, ovrSet, ovrClr;
   logic [DATA_W-1:0] readData;
   logic              unusedData;

   assign unusedData = ^serail_data_i[DATA_W-1:8];

   always_comb begin
      addrOk   = (serail_addr_i >> 2) == '0;
      isData   = addrOk && (serail_addr_i[1:0] == 2'd0);
      isStatus = addrOk && (serail_addr_i[1:0] == 2'd1);
      isCtrl   = addrOk && (serail_addr_i[1:0] == 2'd2);
      access   = (state_q == IDLE) && serail_ce_i;
      txFull   = txCount_q == TX_FULL;
      txEmpty  = txCount_q == '0;
      rxFull   = rxCount_q == RX_FULL;
      rxEmpty  = rxCount_q == '0;
      txPop    = !txEmpty && (drain_q == DR_LAST);
      // A waiting write may take the slot freed by a drain pop on the same edge.
      txPush   = serail_ce_i && serail_we_i && isData &&
                 (((state_q == IDLE) && !txFull) || ((state_q == WAIT) && (!txFull || txPop)));
      rxPop    = access && isData && !serail_we_i && !rxEmpty;
      rxPush   = inject_valid_i && (!rxFull || rxPop);
      ovrSet   = inject_valid_i && rxFull && !rxPop;
      ovrClr   = access && isStatus && serail_we_i && serail_data_i[3];
      txCount_d = txCount_q + (TX_AW+1)'(txPush) - (TX_AW+1)'(txPop);
      rxCount_d = rxCount_q + (RX_AW+1)'(rxPush) - (RX_AW+1)'(rxPop);
      if (txEmpty || txPop) begin
         drain_d = '0;
      end else begin
         drain_d = drain_q + DR_W'(1);
      end
      readData = '0;
      if (isData) begin
         if (!rxEmpty) begin
            readData[7:0] = rxMem_q[rxRd_q];
         end
      end else if (isStatus) begin
         readData[0]     = !txFull;
         readData[1]     = !rxEmpty;
         readData[2]     = txEmpty;
         readData[3]     = ovr_q;
         readData[15:8]  = 8'(rxCount_q);
         readData[23:16] = 8'(txCount_q);
      end else if (isCtrl) begin
         readData[1:0] = ctrl_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
         ovr_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         irq_q <= (ctrl_q[0] && !rxEmpty) || (ctrl_q[1] && txEmpty);
         if (ovrSet) begin
            ovr_q <= 1'b1;
         end else if (ovrClr) begin
            ovr_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (serail_ce_i) begin
                  if (isData && serail_we_i && txFull) begin
                     state_q <= WAIT;
                  end else begin
                     state_q <= DONE;
                     ready_q <= 1'b1;
                     data_q  <= serail_we_i ? '0 : readData;
                     if (isCtrl && serail_we_i) begin
                        ctrl_q <= serail_data_i[1:0];
                     end
                  end
               end
            end
            WAIT: begin
               if (!serail_ce_i) begin
                  state_q <= IDLE;
               end else if (txPush) begin
                  state_q <= DONE;
                  ready_q <= 1'b1;
               end
            end
            DONE: begin
               if (!serail_ce_i) begin
                  state_q <= IDLE;
                  ready_q <= 1'b0;
                  data_q  <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         txWr_q    <= '0;
         txRd_q    <= '0;
         txCount_q <= '0;
         rxWr_q    <= '0;
         rxRd_q    <= '0;
         rxCount_q <= '0;
         drain_q   <= '0;
      end else begin
         if (txPush) begin
            txWr_q <= txWr_q + TX_AW'(1);
         end
         if (txPop) begin
            txRd_q <= txRd_q + TX_AW'(1);
            $write("%c", txMem_q[txRd_q]);
         end
         if (rxPush) begin
            rxWr_q <= rxWr_q + RX_AW'(1);
         end
         if (rxPop) begin
            rxRd_q <= rxRd_q + RX_AW'(1);
         end
         txCount_q <= txCount_d;
         rxCount_q <= rxCount_d;
         drain_q   <= drain_d;
      end
   end

   always_ff @(posedge clk) begin
      if (txPush) begin
         txMem_q[txWr_q] <= serail_data_i[7:0];
      end
      if (rxPush) begin
         rxMem_q[rxWr_q] <= inject_data_i;
      end
   end

   assign serail_data_o  = data_q;
   assign serail_ready_o = ready_q;
   assign irq_o          = irq_q;
   assign inject_ready_o = !rxFull;
endmodule
